// File: rtl/f2i_engine.sv
// Half-precision float to 16-bit two's-complement integer converter on the byte-wide data-memory port.
// Define F2I_ROUND_EN for round-to-nearest-even; the default build truncates toward zero.
module f2i_engine #(
  parameter logic [7:0] SRC_ADDR = 8'd128,
  parameter logic [7:0] DST_ADDR = 8'd130
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic [7:0] mem_addr,
  output logic       mem_ren,
  output logic       mem_wen,
  output logic [7:0] mem_wdata,
  input  logic [7:0] mem_rdata,
  output logic [2:0] dbg_state
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] RD_HI = 3'd1;
  localparam logic [2:0] RD_LO = 3'd2;
  localparam logic [2:0] PREP  = 3'd3;
  localparam logic [2:0] SHIFT = 3'd4;
  localparam logic [2:0] WR_HI = 3'd5;
  localparam logic [2:0] WR_LO = 3'd6;
`ifdef F2I_ROUND_EN
  localparam logic [2:0] ROUND = 3'd7;
  localparam logic [2:0] POST_SHIFT = ROUND;
  // e=14 values can still round up to 1, so they enter the shifter.
  localparam logic [4:0] MIN_EXP = 5'd14;
`else
  localparam logic [2:0] POST_SHIFT = WR_HI;
  localparam logic [4:0] MIN_EXP = 5'd15;
`endif

  logic [2:0]  state_q, state_d;
  logic [7:0]  hi_q, hi_d;
  logic [7:0]  lo_q, lo_d;
  logic [15:0] mag_q, mag_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        left_q, left_d;
  logic        sat_q, sat_d;
  logic        done_q, done_d;
`ifdef F2I_ROUND_EN
  logic        guard_q, guard_d;
  logic        sticky_q, sticky_d;
  logic [16:0] round_sum;
  assign round_sum = {1'b0, mag_q} + {16'd0, guard_q & (sticky_q | mag_q[0])};
`endif

  logic [4:0]  exp_f;
  logic [15:0] result;

  assign exp_f = hi_q[6:2];
  // Saturation values are final; everything else is sign-magnitude converted here.
  assign result = sat_q ? (hi_q[7] ? 16'h8000 : 16'h7FFF)
                        : (hi_q[7] ? (~mag_q + 16'd1) : mag_q);

  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign dbg_state = state_q;

  always_comb begin
    state_d   = state_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    mag_d     = mag_q;
    cnt_d     = cnt_q;
    left_d    = left_q;
    sat_d     = sat_q;
    done_d    = done_q;
`ifdef F2I_ROUND_EN
    guard_d   = guard_q;
    sticky_d  = sticky_q;
`endif
    mem_addr  = 8'h00;
    mem_ren   = 1'b0;
    mem_wen   = 1'b0;
    mem_wdata = 8'h00;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RD_HI;
          done_d  = 1'b0;
        end
      end
      RD_HI: begin
        mem_addr = SRC_ADDR;
        mem_ren  = 1'b1;
        hi_d     = mem_rdata;
        state_d  = RD_LO;
      end
      RD_LO: begin
        mem_addr = SRC_ADDR + 8'd1;
        mem_ren  = 1'b1;
        lo_d     = mem_rdata;
        state_d  = PREP;
      end
      PREP: begin
        sat_d  = 1'b0;
        left_d = 1'b0;
        cnt_d  = 4'd0;
        mag_d  = {5'b0, 1'b1, hi_q[1:0], lo_q};
`ifdef F2I_ROUND_EN
        guard_d  = 1'b0;
        sticky_d = 1'b0;
`endif
        // Shift distance is |e - 25|: the mantissa's LSB sits at 2^(e-25).
        if (exp_f >= 5'd30) begin
          sat_d = 1'b1;
          mag_d = 16'd0;
        end else if (exp_f < MIN_EXP) begin
          mag_d = 16'd0;
        end else if (exp_f > 5'd25) begin
          left_d = 1'b1;
          cnt_d  = 4'(exp_f - 5'd25);
        end else begin
          cnt_d = 4'(5'd25 - exp_f);
        end
        state_d = (cnt_d != 4'd0) ? SHIFT : POST_SHIFT;
      end
      SHIFT: begin
        if (left_q) begin
          mag_d = {mag_q[14:0], 1'b0};
        end else begin
          mag_d = {1'b0, mag_q[15:1]};
`ifdef F2I_ROUND_EN
          guard_d  = mag_q[0];
          sticky_d = sticky_q | guard_q;
`endif
        end
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = POST_SHIFT;
      end
`ifdef F2I_ROUND_EN
      ROUND: begin
        mag_d = round_sum[15:0];
        if (round_sum == 17'h08000 && !hi_q[7]) sat_d = 1'b1;
        state_d = WR_HI;
      end
`endif
      WR_HI: begin
        mem_addr  = DST_ADDR;
        mem_wen   = 1'b1;
        mem_wdata = result[15:8];
        state_d   = WR_LO;
      end
      WR_LO: begin
        mem_addr  = DST_ADDR + 8'd1;
        mem_wen   = 1'b1;
        mem_wdata = result[7:0];
        state_d   = IDLE;
        done_d    = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      hi_q     <= 8'h00;
      lo_q     <= 8'h00;
      mag_q    <= 16'h0000;
      cnt_q    <= 4'd0;
      left_q   <= 1'b0;
      sat_q    <= 1'b0;
      done_q   <= 1'b0;
`ifdef F2I_ROUND_EN
      guard_q  <= 1'b0;
      sticky_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      mag_q    <= mag_d;
      cnt_q    <= cnt_d;
      left_q   <= left_d;
      sat_q    <= sat_d;
      done_q   <= done_d;
`ifdef F2I_ROUND_EN
      guard_q  <= guard_d;
      sticky_q <= sticky_d;
`endif
    end
  end

endmodule

// File: doc/f2i_engine.md
Name: f2i_engine

Overview:
- Multi-cycle float-to-int accelerator on the data-memory port: the hardware counterpart of the int2float program, converting in the other direction.
- On `start`, reads a 16-bit half-precision value (sign, 5-bit exponent with bias 15, 10-bit mantissa) from data memory.
- Converts it to a 16-bit two's-complement integer, writes the result back to data memory, then raises `done`.
- Shares the byte-wide, combinational-read data_mem interface with the core, selected by arbitration at the top level.

Parameters:
- SRC_ADDR, 8'd128, address of source high byte; low byte is at SRC_ADDR+1 (mod 256).
- DST_ADDR, 8'd130, address of result high byte; low byte is at DST_ADDR+1 (mod 256).

Ports:
- clk  in  1  clock, all state on rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- start  in  1  one-cycle request; sampled only in IDLE.
- busy  out  1  high from the cycle after start is accepted until the write completes.
- done  out  1  level; high after completion, cleared when the next start is accepted.
- mem_addr  out  8  data-memory address.
- mem_ren  out  1  read enable.
- mem_wen  out  1  write enable.
- mem_wdata  out  8  write data.
- mem_rdata  in  8  combinational read data for the current mem_addr.

Behaviour:
- Reset values: state IDLE; busy, done, mem_ren, mem_wen = 0; mem_addr = 8'h00; mem_wdata = 8'h00; internal registers cleared.
- Reset mid-operation aborts immediately; no write occurs after reset asserts.
- IDLE: start=1 -> RD_HI and clear done. start while busy is ignored.
- RD_HI: mem_addr=SRC_ADDR, mem_ren=1, latch mem_rdata as hi byte -> RD_LO.
- RD_LO: mem_addr=SRC_ADDR+1, mem_ren=1, latch lo byte -> PREP.
- PREP: split into sign s, exponent e, mantissa m. Set mag = {5'b0, 1, m} (16 bits) and compute shift k = e-25.
  - e<15: mag=0, n=0.
  - e>=30 (includes inf/NaN): saturate. Result is 16'h7FFF if s=0, 16'h8000 if s=1; n=0.
  - otherwise: n=|k|, direction = left if k>0, right if k<0.
  - Then -> SHIFT if n>0, else WR_HI.
- SHIFT: shift mag one bit per cycle in the chosen direction; decrement counter; when counter reaches 0 -> WR_HI.
  - Max n is 10 (right) or 4 (left).
  - Right shifts truncate toward zero.
- Result: the two's-complement negation of mag if s=1, else mag. The saturation values bypass this negation.
- WR_HI: mem_addr=DST_ADDR, mem_wen=1, mem_wdata=result[15:8] -> WR_LO.
- WR_LO: mem_addr=DST_ADDR+1, mem_wen=1, mem_wdata=result[7:0] -> IDLE with done=1, busy=0.
- Outside the RD/WR states: mem_ren=0, mem_wen=0. mem_ren and mem_wen are never both high.
- Latency: done rises on the 5+n-th rising edge after the edge that accepted start.
- Any input with result 0 produces 16'h0000, including -0 and denormals.

Optional Feature:
- Macro F2I_ROUND_EN.
  - Defined: round to nearest, ties to even, instead of truncating.
  - e=14 also goes through the shifter with n=11.
  - Guard and sticky bits are collected during right shifts.
  - A ROUND state between SHIFT/PREP and WR_HI adds 1 cycle on every conversion, so latency is 6+n.
  - If rounding yields magnitude 32768 with s=0, the result saturates to 16'h7FFF.
- Undefined: truncation as specified above, and the ROUND state is absent.

Test Plan:
- mem[128:129]=8'h4A,8'h40 (12.5), pulse start -> mem[130]=8'h00, mem[131]=8'h0C; done on edge 12 (n=7). With F2I_ROUND_EN: same value, done on edge 13.
- 16'hC500 (-5.0) -> 16'hFFFB, edge 13. 16'h3C00 (1.0) -> 16'h0001. 16'h3800 (0.5) -> 16'h0000 in both modes.
- 16'h6E00 (6144, left shift 2) -> 16'h1800, done on edge 7.
- Saturation: 16'h7BFF -> 16'h7FFF; 16'hFC00 -> 16'h8000; 16'h7E00 (NaN) -> 16'h7FFF; each done on edge 5.
- Handshake: assert start again during SHIFT -> ignored, exactly 2 writes occur. A start issued after done -> done clears the next cycle.
- Drop reset (0) during SHIFT -> busy=0, no mem_wen pulse, destination memory unchanged. A new start after release completes normally.
